// File: rtl/mul_pkg.sv
// Shared op codes, state encoding and helpers for the RV64M multiply unit.
// Decode helpers live here so the top and the bench agree on signedness.
package mul_pkg;

    localparam logic [2:0] MUL    = 3'd0;
    localparam logic [2:0] MULH   = 3'd1;
    localparam logic [2:0] MULHSU = 3'd2;
    localparam logic [2:0] MULHU  = 3'd3;
    localparam logic [2:0] MULW   = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    function automatic logic op_reserved(input logic [2:0] op);
        return (op > MULW);
    endfunction

    function automatic logic op_sign_x(input logic [2:0] op);
        return (op == MULH) || (op == MULHSU);
    endfunction

    function automatic logic op_sign_y(input logic [2:0] op);
        return (op == MULH);
    endfunction

    // Only the high-half ops depend on operand signedness.
    function automatic logic op_uses_sign(input logic [2:0] op);
        return (op == MULH) || (op == MULHSU) || (op == MULHU);
    endfunction

    function automatic logic [63:0] select_result(input logic [2:0] op,
                                                  input logic [127:0] prod);
        logic [63:0] res;
        res = '0;
        case (op)
            MUL:                  res = prod[63:0];
            MULH, MULHSU, MULHU:  res = prod[127:64];
            MULW:                 res = {{32{prod[31]}}, prod[31:0]};
            default:              res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mul128.sv
// Combinational 64x64 -> 128-bit product core with per-operand signedness.
// Operands are extended to 128 bits so a plain modular multiply yields the signed product.
module mul128 (
    input  logic [63:0]  a,
    input  logic [63:0]  b,
    input  logic         sign_a,
    input  logic         sign_b,
    output logic [127:0] product
);

    logic [127:0] w_a_ext;
    logic [127:0] w_b_ext;

    assign w_a_ext = {{64{sign_a & a[63]}}, a};
    assign w_b_ext = {{64{sign_b & b[63]}}, b};
    assign product = w_a_ext * w_b_ext;

endmodule

// File: rtl/mul_unit.sv
// RV64M multiply unit: registered operands, one-cycle product core and a
// single-entry product cache that lets repeated operand pairs skip CALC.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a request
// CALC  | operand registers drive mul128; result and product captured this cycle
// DONE  | out_valid=1, result held until out_ready
module mul_unit
    import mul_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    mul_state_t        r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_result;

    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_rs1;
    logic [XLEN-1:0]   r_rs2;

    logic              r_c_valid;
    logic [XLEN-1:0]   r_c_rs1;
    logic [XLEN-1:0]   r_c_rs2;
    logic              r_c_sx;
    logic              r_c_sy;
    logic [2*XLEN-1:0] r_c_prod;

    logic              w_accept;
    logic              w_hit;
    logic              w_sign_match;
    logic [2*XLEN-1:0] w_prod;
    logic              w_calc_sx;
    logic              w_calc_sy;

    assign w_accept  = in_valid & r_in_ready;
    assign w_calc_sx = op_sign_x(r_op);
    assign w_calc_sy = op_sign_y(r_op);

    mul128 u_mul128 (
        .a       (r_rs1),
        .b       (r_rs2),
        .sign_a  (w_calc_sx),
        .sign_b  (w_calc_sy),
        .product (w_prod)
    );

    // Low product bits are sign-independent, so MUL/MULW skip the flag match.
    assign w_sign_match = !op_uses_sign(op) ||
                          ((op_sign_x(op) == r_c_sx) && (op_sign_y(op) == r_c_sy));
    assign w_hit = r_c_valid && !op_reserved(op) &&
                   (rs1 == r_c_rs1) && (rs2 == r_c_rs2) && w_sign_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_op        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op       <= op;
                        r_rs1      <= rs1;
                        r_rs2      <= rs2;
                        r_in_ready <= 1'b0;
                        if (w_hit) begin
                            r_result    <= select_result(op, r_c_prod);
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_result    <= select_result(r_op, w_prod);
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Cache is filled only by a completed, non-reserved CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_valid <= 1'b0;
            r_c_rs1   <= '0;
            r_c_rs2   <= '0;
            r_c_sx    <= 1'b0;
            r_c_sy    <= 1'b0;
            r_c_prod  <= '0;
        end else if (!flush && (r_state == CALC) && !op_reserved(r_op)) begin
            r_c_valid <= 1'b1;
            r_c_rs1   <= r_rs1;
            r_c_rs2   <= r_rs2;
            r_c_sx    <= w_calc_sx;
            r_c_sy    <= w_calc_sy;
            r_c_prod  <= w_prod;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
